rotate_ctrl: RTL and testbench
==============================

Name: rotate_ctrl

Overview:
Sequences one piece rotation per request. Computes the rotated 4x4 float mask and asks the board's collision checker whether the mask fits at the current position. With kicks enabled, it retries at shifted columns. It then commits or rejects the result. Sits between the input/game FSM and the board/float registers; owns the only path by which the float mask changes shape.

Parameters:
XW, 5, width of two's-complement column position (arithmetic modulo 2^XW)
YW, 5, width of unsigned row position
TIMEOUT, 15, max cycles to wait for chk_ack before treating the check as a hit

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rot_req  in  1  one-cycle request to rotate; sampled only in IDLE
rot_dir  in  1  0 = clockwise, 1 = counter-clockwise; captured with rot_req
float_in  in  [0:15]  current float mask, row-major, index r*4+c; captured with rot_req
pos_x  in  XW  current column of mask origin; captured with rot_req
pos_y  in  YW  current row of mask origin; captured with rot_req
busy  out  1  high from the cycle after accepted rot_req until done
chk_req  out  1  collision query valid; held until chk_ack
chk_float  out  [0:15]  candidate mask for query
chk_x  out  XW  candidate column
chk_y  out  YW  candidate row (always captured pos_y)
chk_ack  in  1  one-cycle response strobe from checker
chk_hit  in  1  valid with chk_ack; 1 = overlap or out-of-board
done  out  1  one-cycle pulse when rotation resolved
accepted  out  1  valid with done; 1 = new_float/new_x are to be committed
new_float  out  [0:15]  resolved mask; holds last value between operations
new_x  out  XW  resolved column; holds last value between operations

Behaviour:
- Reset values: busy=0, chk_req=0, chk_float=0, chk_x=0, chk_y=0, done=0, accepted=0, new_float=0, new_x=0. FSM=IDLE, kick index=0, timeout counter=0.
- Rotation map for output index i*4+j:
  - Clockwise: src = j*4+3-i.
  - Counter-clockwise: src = (3-j)*4+i.
- FSM states:
  - IDLE: on rot_req, register the rotated mask, pos_x, pos_y and kick=0 → ISSUE.
  - ISSUE: drive chk_req=1 with chk_x = pos_x + offset[kick] → WAIT.
  - WAIT: chk_req held high.
    - chk_ack && !chk_hit → COMMIT.
    - chk_ack && chk_hit, or timeout counter reaches TIMEOUT:
      - another kick offset remains → kick+1, reset counter, go to ISSUE with chk_req dropped one cycle.
      - no offset remains → REJECT.
  - COMMIT: done=1, accepted=1, new_float=candidate, new_x=chk_x → IDLE.
  - REJECT: done=1, accepted=0, new_float=float_in as captured, new_x=pos_x as captured → IDLE.
- Latency: with the checker acking in the cycle after chk_req rises, done arrives 4 cycles after rot_req (one offset).
- rot_req while busy: ignored, not queued.
- chk_ack outside WAIT: ignored.
- Column arithmetic wraps modulo 2^XW; the checker must report wrapped/out-of-board columns as hit.
- Reset mid-operation: immediate return to reset values. No done pulse; the pending query is abandoned.
- rot_dir/float_in/pos changes after capture have no effect on the current operation.

Optional Feature:
- Macro: ROTATE_WALL_KICK_EN.
- Defined: offset sequence is 0, -1, +1 (up to 3 queries).
- Undefined: offset sequence is 0 only; any hit → REJECT. Kick logic is not synthesised.

Decomposition:
- Shared package/header: FSM state encodings, kick offset table, MASK_W=16.
- One sub-module: rotate_4x4 (purely combinational: mask, dir → rotated mask), instantiated once.
- Sequencing lives in rotate_ctrl.

Test Plan:
- Reset, then float_in=0x0F00, dir=0, pos_x=4, checker ack next cycle with hit=0 → chk_float=0x4444, chk_x=4; done&accepted 4 cycles after rot_req; new_float=0x4444.
- Same, dir=1 → chk_float=0x2222, new_float=0x2222.
- With ROTATE_WALL_KICK_EN, pos_x=0, hits on first query only → chk_x sequence 0 then 31 (-1). Accepted, new_x=31.
- Hits on all queries → REJECT after 3 queries (1 without the macro); accepted=0, new_float=0x0F00, new_x unchanged.
- Checker never acks → each query times out after TIMEOUT cycles; final result REJECT; busy deasserts.
- rot_req pulsed while busy, and rst asserted while in WAIT → the busy request is ignored; after rst all outputs return to 0 with no done; the next rot_req is processed normally.

Source files
------------

// File: rtl/rotate_ctrl_pkg.sv
// Shared types and constants for the rotation sequencer.
// ROTATE_WALL_KICK_EN selects the three-entry kick table (0, -1, +1).
package rotate_ctrl_pkg;

    localparam int unsigned MASK_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StCommit,
        StReject
    } state_e;

`ifdef ROTATE_WALL_KICK_EN
    localparam int unsigned NumKicks = 3;

    // Column offset tried for each successive collision query.
    function automatic int kick_offset(input logic [1:0] kick);
        case (kick)
            2'd1:    return -1;
            2'd2:    return 1;
            default: return 0;
        endcase
    endfunction
`endif

endpackage

// File: rtl/rotate_4x4.sv
// Combinational 4x4 mask rotation, row-major with index r*4+c.
module rotate_4x4
    import rotate_ctrl_pkg::*;
(
    input  logic [0:MASK_W-1] mask_i,
    input  logic              dir_i,    // 0 = clockwise, 1 = counter-clockwise
    output logic [0:MASK_W-1] rotated_o
);

    always_comb begin
        rotated_o = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                rotated_o[i*4+j] = dir_i ? mask_i[(3-j)*4+i] : mask_i[j*4+3-i];
            end
        end
    end

endmodule

// File: rtl/rotate_ctrl.sv
// One rotation per request: rotate, query the collision checker, commit or reject.
// ROTATE_WALL_KICK_EN enables retries at column offsets -1 and +1.
module rotate_ctrl
    import rotate_ctrl_pkg::*;
#(
    parameter int unsigned XW      = 5,
    parameter int unsigned YW      = 5,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rot_req,
    input  logic              rot_dir,
    input  logic [0:MASK_W-1] float_in,
    input  logic [XW-1:0]     pos_x,
    input  logic [YW-1:0]     pos_y,
    output logic              busy,
    output logic              chk_req,
    output logic [0:MASK_W-1] chk_float,
    output logic [XW-1:0]     chk_x,
    output logic [YW-1:0]     chk_y,
    input  logic              chk_ack,
    input  logic              chk_hit,
    output logic              done,
    output logic              accepted,
    output logic [0:MASK_W-1] new_float,
    output logic [XW-1:0]     new_x
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    state_e            state_q;
    logic [0:MASK_W-1] rotated;
    logic [0:MASK_W-1] cand_q;
    logic [0:MASK_W-1] float_q;
    logic [XW-1:0]     posx_q;
    logic [YW-1:0]     posy_q;
    logic [CntW-1:0]   cnt_q;
    logic              last_kick;

`ifdef ROTATE_WALL_KICK_EN
    logic [1:0] kick_q;
    assign last_kick = (kick_q == 2'(NumKicks - 1));
`else
    assign last_kick = 1'b1;
`endif

    rotate_4x4 u_rotate (
        .mask_i    (float_in),
        .dir_i     (rot_dir),
        .rotated_o (rotated)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cand_q    <= '0;
            float_q   <= '0;
            posx_q    <= '0;
            posy_q    <= '0;
            cnt_q     <= '0;
`ifdef ROTATE_WALL_KICK_EN
            kick_q    <= '0;
`endif
            busy      <= 1'b0;
            chk_req   <= 1'b0;
            chk_float <= '0;
            chk_x     <= '0;
            chk_y     <= '0;
            done      <= 1'b0;
            accepted  <= 1'b0;
            new_float <= '0;
            new_x     <= '0;
        end else begin
            done     <= 1'b0;
            accepted <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (rot_req) begin
                        cand_q  <= rotated;
                        float_q <= float_in;
                        posx_q  <= pos_x;
                        posy_q  <= pos_y;
                        cnt_q   <= '0;
`ifdef ROTATE_WALL_KICK_EN
                        kick_q  <= '0;
`endif
                        busy    <= 1'b1;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    chk_req   <= 1'b1;
                    chk_float <= cand_q;
`ifdef ROTATE_WALL_KICK_EN
                    chk_x     <= posx_q + XW'(kick_offset(kick_q));
`else
                    chk_x     <= posx_q;
`endif
                    chk_y     <= posy_q;
                    cnt_q     <= '0;
                    state_q   <= StWait;
                end
                StWait: begin
                    if (chk_ack && !chk_hit) begin
                        chk_req   <= 1'b0;
                        done      <= 1'b1;
                        accepted  <= 1'b1;
                        new_float <= cand_q;
                        new_x     <= chk_x;
                        state_q   <= StCommit;
                    end else if (chk_ack || cnt_q == CntW'(TIMEOUT - 1)) begin
                        // A missing ack is treated exactly like a hit.
                        chk_req <= 1'b0;
                        if (!last_kick) begin
`ifdef ROTATE_WALL_KICK_EN
                            kick_q <= kick_q + 2'd1;
`endif
                            cnt_q   <= '0;
                            state_q <= StIssue;
                        end else begin
                            done      <= 1'b1;
                            new_float <= float_q;
                            new_x     <= posx_q;
                            state_q   <= StReject;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StCommit, StReject: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rotate_ctrl.sv
// Self-checking bench for rotate_ctrl: vector table, directed corners, randomized ops vs model.
module tb_rotate_ctrl;

    localparam int unsigned XW      = 5;
    localparam int unsigned YW      = 5;
    localparam int unsigned TIMEOUT = 15;
`ifdef ROTATE_WALL_KICK_EN
    localparam int NK = 3;
`else
    localparam int NK = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          rot_req;
    logic          rot_dir;
    logic [0:15]   float_in;
    logic [XW-1:0] pos_x;
    logic [YW-1:0] pos_y;
    logic          busy;
    logic          chk_req;
    logic [0:15]   chk_float;
    logic [XW-1:0] chk_x;
    logic [YW-1:0] chk_y;
    logic          chk_ack;
    logic          chk_hit;
    logic          done;
    logic          accepted;
    logic [0:15]   new_float;
    logic [XW-1:0] new_x;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rotate_ctrl #(
        .XW      (XW),
        .YW      (YW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rot_req   (rot_req),
        .rot_dir   (rot_dir),
        .float_in  (float_in),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .busy      (busy),
        .chk_req   (chk_req),
        .chk_float (chk_float),
        .chk_x     (chk_x),
        .chk_y     (chk_y),
        .chk_ack   (chk_ack),
        .chk_hit   (chk_hit),
        .done      (done),
        .accepted  (accepted),
        .new_float (new_float),
        .new_x     (new_x)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference rotation on a 2-D grid view of the mask.
    function automatic logic [0:15] rot_ref(input logic [0:15] m, input logic ccw);
        logic        g [4][4];
        logic [0:15] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                g[r][c] = m[r*4+c];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[r*4+c] = ccw ? g[3-c][r] : g[c][3-r];
        return o;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, {28'd0, busy, chk_req, done, accepted}, 32'd0);
        check({tag, "_chk_float"}, chk_float, 32'd0);
        check({tag, "_chk_xy"}, {chk_x, chk_y}, 32'd0);
        check({tag, "_new_float"}, new_float, 32'd0);
        check({tag, "_new_x"}, new_x, 32'd0);
    endtask

    // One full operation. hit/noack give each query's checker behaviour; dly is the
    // number of chk_req-high cycles before the ack strobe.
    task automatic run_op(input logic [0:15] m, input logic d, input logic [XW-1:0] px,
                          input logic [YW-1:0] py, input logic [2:0] hit,
                          input logic [2:0] noack, input int dly, input bit pulse_busy,
                          input bit spur, output int dcyc, output logic acc,
                          output logic [0:15] nf, output logic [XW-1:0] nx);
        int            off [3] = '{0, -1, 1};
        logic [XW-1:0] ex  [3];
        int            exp_q   = 0;
        logic          exp_acc = 1'b0;
        logic [0:15]   exp_nf;
        logic [XW-1:0] exp_nx;
        int            cyc, qn, qi, wc;
        bit            prev, got;
        for (int q = 0; q < 3; q++) ex[q] = px + XW'(off[q]);
        for (int q = 0; q < NK; q++) begin
            exp_q++;
            if (!(hit[q] | noack[q])) begin
                exp_acc = 1'b1;
                break;
            end
        end
        exp_nf = exp_acc ? rot_ref(m, d) : m;
        exp_nx = exp_acc ? ex[exp_q-1] : px;

        @(negedge clk);
        rot_req = 1'b1; float_in = m; rot_dir = d; pos_x = px; pos_y = py;
        @(negedge clk);
        rot_req = 1'b0;
        float_in = 16'($urandom); rot_dir = 1'($urandom);
        pos_x = XW'($urandom); pos_y = YW'($urandom);
        check("busy_set", busy, 1);
        cyc = 1; qn = 0; wc = 0; prev = 0; got = 0;
        dcyc = -1; acc = 1'bx; nf = 'x; nx = 'x;
        while (cyc < 200) begin
            chk_ack = 1'b0;
            chk_hit = 1'($urandom);
            rot_req = (pulse_busy && cyc == 2);
            if (rot_req) begin
                float_in = 16'($urandom); rot_dir = 1'($urandom);
            end
            if (done) begin
                got = 1; dcyc = cyc; acc = accepted; nf = new_float; nx = new_x;
                break;
            end
            if (chk_req) begin
                if (!prev) begin
                    qi = (qn < 3) ? qn : 2;
                    check("chk_x", chk_x, ex[qi]);
                    check("chk_float", chk_float, rot_ref(m, d));
                    check("chk_y", chk_y, py);
                    qn++;
                    wc = 0;
                end else begin
                    wc++;
                end
                qi = (qn < 4) ? qn - 1 : 2;
                if (!noack[qi] && wc == dly) begin
                    chk_ack = 1'b1;
                    chk_hit = hit[qi];
                end
            end else begin
                if (prev) begin
                    qi = (qn < 4) ? qn - 1 : 2;
                    if (noack[qi]) check("timeout_len", wc + 1, TIMEOUT);
                end
                if (spur) begin
                    chk_ack = 1'($urandom);
                    chk_hit = 1'b0;
                end
            end
            prev = chk_req;
            @(negedge clk);
            cyc++;
        end
        rot_req = 1'b0;
        chk_ack = 1'b0;
        check("done_seen", got, 1);
        check("query_count", qn, exp_q);
        check("accepted", acc, exp_acc);
        check("new_float", nf, exp_nf);
        check("new_x", nx, exp_nx);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("busy_clear", busy, 0);
        if (pulse_busy) begin
            repeat (3) begin
                @(negedge clk);
                check("busy_req_ignored", {busy, chk_req}, 0);
            end
        end
    endtask

    typedef struct {
        logic [15:0] mask;
        logic        dir;
        logic [15:0] exp;
    } rot_vec_t;

    initial begin
        rot_vec_t      tv [8];
        int            dcyc;
        logic          acc;
        logic [0:15]   nf;
        logic [XW-1:0] nx;
        bit            seen;

        tv[0] = '{16'h0F00, 1'b0, 16'h4444};
        tv[1] = '{16'h0F00, 1'b1, 16'h2222};
        tv[2] = '{16'h8000, 1'b0, 16'h0008};
        tv[3] = '{16'h8000, 1'b1, 16'h1000};
        tv[4] = '{16'h0001, 1'b0, 16'h1000};
        tv[5] = '{16'h0001, 1'b1, 16'h0008};
        tv[6] = '{16'hFFFF, 1'b0, 16'hFFFF};
        tv[7] = '{16'h0000, 1'b1, 16'h0000};

        rst = 1'b1; rot_req = 1'b0; rot_dir = 1'b0; float_in = '0;
        pos_x = '0; pos_y = '0; chk_ack = 1'b0; chk_hit = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Basic clockwise commit with latency.
        run_op(16'h0F00, 1'b0, 5'd4, 5'd9, 3'b000, 3'b000, 1, 0, 0, dcyc, acc, nf, nx);
        check("latency", dcyc, 4);
        check("tp1_new_float", nf, 16'h4444);
        check("tp1_new_x", nx, 4);

        run_op(16'h0F00, 1'b1, 5'd4, 5'd9, 3'b000, 3'b000, 1, 0, 0, dcyc, acc, nf, nx);
        check("tp2_new_float", nf, 16'h2222);

        for (int i = 0; i < 8; i++) begin
            run_op(tv[i].mask, tv[i].dir, XW'(i * 3), YW'(i), 3'b000, 3'b000, 1, 0, 0,
                   dcyc, acc, nf, nx);
            check("tbl_new_float", nf, tv[i].exp);
            check("tbl_accepted", acc, 1);
        end

        // Left-edge hit on the first query.
        run_op(16'h0F00, 1'b0, 5'd0, 5'd3, 3'b001, 3'b000, 1, 0, 0, dcyc, acc, nf, nx);
`ifdef ROTATE_WALL_KICK_EN
        check("kick_accepted", acc, 1);
        check("kick_new_x", nx, 31);
`else
        check("kick_accepted", acc, 0);
        check("kick_new_x", nx, 0);
`endif

        // Every query hits.
        run_op(16'h0F00, 1'b0, 5'd7, 5'd3, 3'b111, 3'b000, 2, 0, 0, dcyc, acc, nf, nx);
        check("allhit_accepted", acc, 0);
        check("allhit_new_float", nf, 16'h0F00);
        check("allhit_new_x", nx, 7);

        // Checker silent: every query times out.
        run_op(16'h0F00, 1'b1, 5'd12, 5'd1, 3'b000, 3'b111, 1, 0, 0, dcyc, acc, nf, nx);
        check("timeout_accepted", acc, 0);

        // Request while busy is dropped.
        run_op(16'h3300, 1'b0, 5'd10, 5'd2, 3'b000, 3'b000, 1, 1, 0, dcyc, acc, nf, nx);

        // Reset while waiting for the checker.
        @(negedge clk);
        rot_req = 1'b1; float_in = 16'hF000; rot_dir = 1'b0; pos_x = 5'd6; pos_y = 5'd5;
        @(negedge clk);
        rot_req = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (chk_req) seen = 1;
            else @(negedge clk);
        end
        check("rst_reached_wait", seen, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("midop_rst");
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || chk_req || busy) seen = 1;
        end
        check("rst_no_activity", seen, 0);
        run_op(16'h0F00, 1'b0, 5'd4, 5'd9, 3'b000, 3'b000, 1, 0, 0, dcyc, acc, nf, nx);
        check("post_rst_new_float", nf, 16'h4444);

        // Randomized operations against the model.
        for (int n = 0; n < 40; n++) begin
            logic [2:0] na;
            for (int b = 0; b < 3; b++) na[b] = ($urandom_range(0, 7) == 0);
            run_op(16'($urandom), 1'($urandom), XW'($urandom), YW'($urandom),
                   3'($urandom), na, $urandom_range(1, 3), bit'($urandom_range(0, 1)), 1,
                   dcyc, acc, nf, nx);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
